// File: rtl/ghffe_pkg.sv
// Shared constants and FSM state encoding for the FFT-board note link.
// The SC/AV blocks import NUM_NOTES from here so every consumer agrees on the vector width.
package ghffe_pkg;

   // Number of note bits carried in one frame. This is also the width of the active vector.
   localparam int NUM_NOTES = 48;

   // One even-parity bit follows the data bits in every frame.
   localparam int PARITY_BITS = 1;

   // Receiver FSM states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RECV     = 2'd1,
      CHECK    = 2'd2,
      WAIT_LOW = 2'd3
   } rx_state_t;

endpackage

// File: rtl/note_frame_receiver_sync_2ff.sv
// Two-flop synchronizer for one asynchronous PMOD line.
// Sync and data each use an identical copy, so both lines see the same latency.
module sync_2ff (
   input  logic clk,
   input  logic raw,
   output logic synced
);

   logic meta;

   // There is no reset here. The first flop may go metastable and the second flop resolves it.
   always_ff @(posedge clk) begin
      meta   <= raw;
      synced <= meta;
   end

endmodule

// File: rtl/note_frame_receiver.sv
// Deframes note-activity frames from the FFT board (JA[1] = sync, JA[0] = data).
// The last good frame is held on active. active[35:0] feeds NDATA[36:1] downstream.
module note_frame_receiver
   import ghffe_pkg::*;
#(
   parameter int NUM_NOTES      = ghffe_pkg::NUM_NOTES,
   parameter int BIT_CYCLES     = 100,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ser_sync,
   input  logic                 ser_data,
   output logic [NUM_NOTES-1:0] active,
   output logic                 frame_valid,
   output logic                 link_up,
   output logic [7:0]           err_count
);

   localparam int BW = $clog2(NUM_NOTES + PARITY_BITS);
   localparam int CW = $clog2(BIT_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   // The parity bit is the last bit of the frame. Its index equals the number of data bits.
   localparam logic [BW-1:0] PARITY_IDX = BW'(NUM_NOTES + PARITY_BITS - 1);
   localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] SAMPLE_AT  = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    ERR_MAX    = 8'hFF;

   logic                 sync_q;
   logic                 data_q;
   logic                 sync_q_d;
   logic                 sync_rise;
   rx_state_t            state;
   logic [BW-1:0]        bit_cnt;
   logic [CW-1:0]        cyc_cnt;
   logic [NUM_NOTES-1:0] shreg;
   logic                 par;
   logic [TW-1:0]        tmo_cnt;

   sync_2ff u_sync_sync (
      .clk    (clk),
      .raw    (ser_sync),
      .synced (sync_q)
   );

   sync_2ff u_sync_data (
      .clk    (clk),
      .raw    (ser_data),
      .synced (data_q)
   );

   // Delayed copy of sync for edge detection. It is deliberately left unreset, so a sync line
   // that stays high through reset does not look like a fresh frame start afterwards.
   always_ff @(posedge clk) begin
      sync_q_d <= sync_q;
   end

   assign sync_rise = sync_q & ~sync_q_d;

   // Receiver FSM, bit timing, shift register, parity, error count and link-timeout watchdog.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         cyc_cnt     <= '0;
         shreg       <= '0;
         par         <= 1'b0;
         tmo_cnt     <= '0;
         active      <= '0;
         frame_valid <= 1'b0;
         link_up     <= 1'b0;
         err_count   <= '0;
      end else begin
         frame_valid <= 1'b0;

         if (tmo_cnt == TMO_LAST) begin
            active  <= '0;
            link_up <= 1'b0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         case (state)
            IDLE: begin
               if (sync_rise) begin
                  state   <= RECV;
                  bit_cnt <= '0;
                  cyc_cnt <= '0;
                  par     <= 1'b0;
               end
            end

            RECV: begin
               if (!sync_q) begin
                  if (err_count != ERR_MAX) begin
                     err_count <= err_count + 8'd1;
                  end
                  state <= IDLE;
               end else begin
                  cyc_cnt <= (cyc_cnt == CYC_LAST) ? '0 : cyc_cnt + CW'(1);
                  if (cyc_cnt == SAMPLE_AT) begin
                     par <= par ^ data_q;
                     if (bit_cnt == PARITY_IDX) begin
                        state <= CHECK;
                     end else begin
                        shreg   <= {shreg[NUM_NOTES-2:0], data_q};
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end
               end
            end

            CHECK: begin
               if (!par) begin
                  active      <= shreg;
                  frame_valid <= 1'b1;
                  link_up     <= 1'b1;
                  tmo_cnt     <= '0;
               end else if (err_count != ERR_MAX) begin
                  err_count <= err_count + 8'd1;
               end
               state <= WAIT_LOW;
            end

            WAIT_LOW: begin
               if (!sync_q) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_frame_receiver.sv
// Directed bench for note_frame_receiver: good, bad-parity, short and held-sync frames,
// link timeout, error-count saturation, and reset in the middle of a frame.
module tb_note_frame_receiver;

   localparam int NN        = 48;
   localparam int BC        = 8;
   localparam int TC        = 1000;
   localparam int FRAME_LEN = (NN + 1) * BC;

   logic          clk = 1'b0;
   logic          reset;
   logic          ser_sync;
   logic          ser_data;
   logic [NN-1:0] active;
   logic          frame_valid;
   logic          link_up;
   logic [7:0]    err_count;

   int errors   = 0;
   int checks   = 0;
   int cyc_now  = 0;
   int fv_count = 0;
   int fv_cycle = 0;

   note_frame_receiver #(
      .NUM_NOTES      (NN),
      .BIT_CYCLES     (BC),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ser_sync    (ser_sync),
      .ser_data    (ser_data),
      .active      (active),
      .frame_valid (frame_valid),
      .link_up     (link_up),
      .err_count   (err_count)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Free-running cycle counter, used to time the link watchdog.
   always @(posedge clk) cyc_now <= cyc_now + 1;

   // Count frame_valid cycles and remember when the latest one was seen.
   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         fv_count++;
         fv_cycle = cyc_now;
      end
   end

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Sends one frame MSB first with even parity. flip inverts the parity bit. nbits is the number
   // of bit times before sync drops, skew shifts the data edges relative to sync, and hold keeps
   // sync high for extra cycles after those bits.
   task automatic send_frame(input logic [NN-1:0] data, input logic flip, input int nbits,
                             input int skew, input int hold);
      logic [NN:0] frame;
      int          idx;
      frame = {data, (^data) ^ flip};
      for (int c = 0; c < nbits * BC + hold; c++) begin
         @(negedge clk);
         ser_sync = 1'b1;
         idx = (c - skew < 0) ? 0 : (c - skew) / BC;
         if (idx > NN) idx = NN;
         ser_data = frame[NN - idx];
      end
      @(negedge clk);
      ser_sync = 1'b0;
      ser_data = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      int fv_before;
      int n;

      // Reset state
      reset    = 1'b1;
      ser_sync = 1'b0;
      ser_data = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_output("reset_active",  active,      '0);
      check_output("reset_fv",      frame_valid, 1'b0);
      check_output("reset_link",    link_up,     1'b0);
      check_output("reset_err",     err_count,   8'd0);

      // 1. Good frame
      fv_before = fv_count;
      send_frame(48'h8000_0000_0001, 1'b0, NN + 1, 0, 0);
      check_output("t1_active", active, 48'h8000_0000_0001);
      check_output("t1_pulses", fv_count - fv_before, 1);
      check_output("t1_link",   link_up, 1'b1);
      check_output("t1_err",    err_count, 8'd0);
      check_output("t1_fv_low", frame_valid, 1'b0);

      // 2. Parity error
      fv_before = fv_count;
      send_frame(48'h0000_0000_0007, 1'b1, NN + 1, 0, 0);
      check_output("t2_active", active, 48'h8000_0000_0001);
      check_output("t2_pulses", fv_count - fv_before, 0);
      check_output("t2_err",    err_count, 8'd1);
      check_output("t2_link",   link_up, 1'b1);

      // 3. Short frame, then good frame with late data edges
      fv_before = fv_count;
      send_frame(48'hFFFF_FFFF_FFFF, 1'b0, 20, 0, 0);
      check_output("t3_short_err",    err_count, 8'd2);
      check_output("t3_short_active", active, 48'h8000_0000_0001);
      check_output("t3_short_pulses", fv_count - fv_before, 0);
      send_frame(48'h0F0F_0F0F_0F0F, 1'b0, NN + 1, 3, 0);
      check_output("t3_good_active", active, 48'h0F0F_0F0F_0F0F);
      check_output("t3_good_pulses", fv_count - fv_before, 1);

      // 4. Link timeout
      send_frame(48'h0000_0055_AA00, 1'b0, NN + 1, 0, 0);
      check_output("t4_active", active, 48'h0000_0055_AA00);
      n = 0;
      while (active !== '0 && n < 2 * TC) begin
         @(negedge clk);
         n++;
      end
      check_output("t4_timeout_cycles", cyc_now - fv_cycle, TC);
      check_output("t4_active_cleared", active, '0);
      check_output("t4_link_down",      link_up, 1'b0);
      send_frame(48'h0000_0000_0100, 1'b0, NN + 1, 0, 0);
      check_output("t4_link_back", link_up, 1'b1);
      check_output("t4_active_back", active, 48'h0000_0000_0100);

      // 5. Error saturation, then reset in the middle of a frame
      for (int i = 0; i < 3; i++) send_frame(48'hA5A5_0000_1234, 1'b1, NN + 1, 0, 0);
      check_output("t5_err5", err_count, 8'd5);
      for (int i = 0; i < 249; i++) send_frame(48'h0, 1'b0, 1, 0, 0);
      check_output("t5_err254", err_count, 8'd254);
      send_frame(48'h0, 1'b0, 1, 0, 0);
      check_output("t5_err255", err_count, 8'd255);
      for (int i = 0; i < 10; i++) send_frame(48'h0, 1'b0, 1, 0, 0);
      check_output("t5_err_sat", err_count, 8'd255);
      send_frame(48'h1234_5678_9ABC, 1'b0, NN + 1, 0, 0);
      check_output("t5_pre_active", active, 48'h1234_5678_9ABC);
      for (int c = 0; c < 20 * BC; c++) begin
         @(negedge clk);
         ser_sync = 1'b1;
         ser_data = c[3];
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      fv_before = fv_count;
      repeat (FRAME_LEN + 20) @(negedge clk);
      check_output("t5_rst_active", active, '0);
      check_output("t5_rst_link",   link_up, 1'b0);
      check_output("t5_rst_err",    err_count, 8'd0);
      check_output("t5_rst_pulses", fv_count - fv_before, 0);
      ser_sync = 1'b0;
      ser_data = 1'b0;
      repeat (8) @(negedge clk);
      check_output("t5_rst_err_after", err_count, 8'd0);

      // 6. Sync held high for three frame lengths, early data edges
      fv_before = fv_count;
      send_frame(48'hC0FF_EE12_3456, 1'b0, NN + 1, -3, 2 * FRAME_LEN);
      check_output("t6_pulses", fv_count - fv_before, 1);
      check_output("t6_active", active, 48'hC0FF_EE12_3456);
      check_output("t6_link",   link_up, 1'b1);
      check_output("t6_err",    err_count, 8'd0);
      fv_before = fv_count;
      send_frame(48'h0000_FFFF_0001, 1'b0, NN + 1, 3, 0);
      check_output("t6_late_pulses", fv_count - fv_before, 1);
      check_output("t6_late_active", active, 48'h0000_FFFF_0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
